conv_weight_loader: RTL and testbench

Parametrised weight loader for the variable-channel CNN convolution layers. On `start` it streams `OUT_CH*IN_CH*KERNEL` weights from an external synchronous weight ROM into an internal buffer. On `layer_go` it presents one tap at a time as a full `OUT_CH x IN_CH` weight vector over a valid/ready handshake. It sits between the per-layer weight ROM and the layer's multiplier array, and is reusable across layers via `rom_base`, with repeatable emission and reload.

---
 rtl/conv_weight_loader_if.sv | 35 +++
 rtl/conv_weight_loader.sv | 169 ++++++++++++++++
 tb/tb_conv_weight_loader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_weight_loader_if.sv
// conv_weight_loader_if
// Bundles the two data-side buses of the weight loader:
//   - ROM read port : rom_en, rom_addr (loader -> ROM), rom_dout (ROM -> loader)
//   - weight stream : w_valid, w_tap, w_vec, emit_done (loader -> consumer),
//                     w_ready (consumer -> loader)
// master = loader side, slave = ROM/consumer side.
interface conv_weight_loader_if #(
   parameter int WEIGHT_W = 8,
   parameter int KERNEL   = 3,
   parameter int IN_CH    = 4,
   parameter int OUT_CH   = 16,
   parameter int ADDR_W   = 8
);
   localparam int TAP_W = (KERNEL > 1) ? $clog2(KERNEL) : 1;
   localparam int VEC_W = OUT_CH * IN_CH * WEIGHT_W;

   logic                rom_en;
   logic [ADDR_W-1:0]   rom_addr;
   logic [WEIGHT_W-1:0] rom_dout;
   logic                w_valid;
   logic                w_ready;
   logic [TAP_W-1:0]    w_tap;
   logic [VEC_W-1:0]    w_vec;
   logic                emit_done;

   modport master (
      output rom_en, rom_addr, w_valid, w_tap, w_vec, emit_done,
      input  rom_dout, w_ready
   );

   modport slave (
      input  rom_en, rom_addr, w_valid, w_tap, w_vec, emit_done,
      output rom_dout, w_ready
   );
endinterface

// File: rtl/conv_weight_loader.sv
// conv_weight_loader
// Loads OUT_CH*IN_CH*KERNEL weights from a synchronous ROM into a local
// buffer, then replays them one kernel tap at a time as a full
// OUT_CH x IN_CH weight vector over valid/ready.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, rom_base : begin a buffer load from rom_base (IDLE/READY only)
//   layer_go        : request one tap sequence (queued if seen while loading)
//   busy            : buffer load in progress
//   weights_ready   : buffer holds a complete weight set
//   bus (master)    : ROM read port and weight stream (see interface)
module conv_weight_loader #(
   parameter int WEIGHT_W = 8,
   parameter int KERNEL   = 3,
   parameter int IN_CH    = 4,
   parameter int OUT_CH   = 16,
   parameter int ADDR_W   = 8,
   parameter int ROM_LAT  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_W-1:0]   rom_base,
   input  logic                layer_go,
   output logic                busy,
   output logic                weights_ready,
   conv_weight_loader_if.master bus
);
   localparam int N     = OUT_CH * IN_CH * KERNEL;
   localparam int CNT_W = $clog2(N + 1);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int TAP_W = (KERNEL > 1) ? $clog2(KERNEL) : 1;
   localparam int VEC_W = OUT_CH * IN_CH * WEIGHT_W;

   localparam logic [CNT_W-1:0] N_K      = CNT_W'(N);
   localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(N - 1);
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERNEL - 1);

   typedef enum logic [1:0] {IDLE, LOAD, READY, EMIT} state_t;

   state_t              state;
   state_t              state_nx;
   logic [ADDR_W-1:0]   base;
   logic [CNT_W-1:0]    rd_cnt;
   logic                pend;
   logic [TAP_W-1:0]    tap;
   logic                emit_pulse;
   logic                vld_p [ROM_LAT];
   logic [IDX_W-1:0]    idx_p [ROM_LAT];
   logic [WEIGHT_W-1:0] wbuf  [N];
   logic [VEC_W-1:0]    vec;

   logic start_ok;
   logic issue;
   logic wr_en;
   logic wr_last;
   logic hs;
   logic hs_last;
   logic emit_entry;

   assign start_ok   = start && ((state == IDLE) || (state == READY));
   // Reads run while the counter has not reached N; the counter saturates
   // at N for the remainder of LOAD while the ROM pipeline drains.
   assign issue      = (state == LOAD) && (rd_cnt != N_K);
   assign wr_en      = vld_p[ROM_LAT-1];
   assign wr_last    = wr_en && (idx_p[ROM_LAT-1] == LAST_K);
   assign hs         = (state == EMIT) && bus.w_ready;
   assign hs_last    = hs && (tap == LAST_TAP);
   assign emit_entry = (state_nx == EMIT) && (state != EMIT);

   // Next-state logic. A go that is already pending (or arrives in the
   // final write cycle) skips READY so w_valid rises with no gap.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    if (wr_last) state_nx = (pend || layer_go) ? EMIT : READY;
         READY: begin
            if (start)         state_nx = LOAD;
            else if (layer_go) state_nx = EMIT;
         end
         EMIT:    if (hs_last) state_nx = READY;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Load control: base latch, read counter, pending go, tap counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base       <= '0;
         rd_cnt     <= '0;
         pend       <= 1'b0;
         tap        <= '0;
         emit_pulse <= 1'b0;
      end else begin
         if (start_ok) begin
            base   <= rom_base;
            rd_cnt <= '0;
         end else if (issue) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
         end

         // start and layer_go together in READY: start wins, go is queued.
         if ((state == LOAD) && wr_last)
            pend <= 1'b0;
         else if ((state == LOAD) && layer_go)
            pend <= 1'b1;
         else if ((state == READY) && start && layer_go)
            pend <= 1'b1;

         if (emit_entry)   tap <= '0;
         else if (hs_last) tap <= '0;
         else if (hs)      tap <= tap + TAP_W'(1);

         emit_pulse <= hs_last;
      end
   end

   // Stage p0..p(ROM_LAT-1): read-valid and word index follow the ROM latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ROM_LAT; i++) begin
            vld_p[i] <= 1'b0;
            idx_p[i] <= '0;
         end
      end else begin
         vld_p[0] <= issue;
         idx_p[0] <= IDX_W'(rd_cnt);
         for (int i = 1; i < ROM_LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
            idx_p[i] <= idx_p[i-1];
         end
      end
   end

   // Weight buffer: written from the last pipeline stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) wbuf[i] <= '0;
      end else if (wr_en) begin
         wbuf[idx_p[ROM_LAT-1]] <= bus.rom_dout;
      end
   end

   // Tap mux: element e = oc*IN_CH+ic picks word oc*IN_CH*KERNEL+ic*KERNEL+tap.
   always_comb begin
      vec = '0;
      for (int oc = 0; oc < OUT_CH; oc++) begin
         for (int ic = 0; ic < IN_CH; ic++) begin
            vec[(oc*IN_CH+ic)*WEIGHT_W +: WEIGHT_W] =
               wbuf[IDX_W'(oc*IN_CH*KERNEL + ic*KERNEL + int'(tap))];
         end
      end
   end

   assign bus.rom_en     = issue;
   assign bus.rom_addr   = issue ? (base + ADDR_W'(rd_cnt)) : '0;
   assign bus.w_valid    = (state == EMIT);
   assign bus.w_tap      = tap;
   assign bus.w_vec      = vec;
   assign bus.emit_done  = emit_pulse;
   assign busy           = (state == LOAD);
   assign weights_ready  = (state == READY) || (state == EMIT);
endmodule

// File: tb/tb_conv_weight_loader.sv
module tb_conv_weight_loader;
   localparam int WEIGHT_W = 8;
   localparam int KERNEL   = 3;
   localparam int IN_CH    = 4;
   localparam int OUT_CH   = 16;
   localparam int ADDR_W   = 8;
   localparam int N        = OUT_CH * IN_CH * KERNEL;
   localparam int TAP_W    = (KERNEL > 1) ? $clog2(KERNEL) : 1;
   localparam int VEC_W    = OUT_CH * IN_CH * WEIGHT_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, layer_go = 1'b0;
   logic start2 = 1'b0, layer_go2 = 1'b0;
   logic [ADDR_W-1:0] rom_base = '0, rom_base2 = '0;
   logic busy, weights_ready, busy2, weights_ready2;

   int n_total = 0;
   int n_pass  = 0;

   logic [7:0]       rom_mem [256];
   logic [VEC_W-1:0] cap_vec [KERNEL];
   logic [7:0]       rom1, rom2_a, rom2_b;

   conv_weight_loader_if #(.WEIGHT_W(WEIGHT_W), .KERNEL(KERNEL), .IN_CH(IN_CH),
      .OUT_CH(OUT_CH), .ADDR_W(ADDR_W)) bus1 ();
   conv_weight_loader_if #(.WEIGHT_W(WEIGHT_W), .KERNEL(KERNEL), .IN_CH(IN_CH),
      .OUT_CH(OUT_CH), .ADDR_W(ADDR_W)) bus2 ();

   conv_weight_loader #(.WEIGHT_W(WEIGHT_W), .KERNEL(KERNEL), .IN_CH(IN_CH),
      .OUT_CH(OUT_CH), .ADDR_W(ADDR_W), .ROM_LAT(1)) u_dut (
      .clk(clk), .rst(rst), .start(start), .rom_base(rom_base),
      .layer_go(layer_go), .busy(busy), .weights_ready(weights_ready), .bus(bus1));

   conv_weight_loader #(.WEIGHT_W(WEIGHT_W), .KERNEL(KERNEL), .IN_CH(IN_CH),
      .OUT_CH(OUT_CH), .ADDR_W(ADDR_W), .ROM_LAT(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .rom_base(rom_base2),
      .layer_go(layer_go2), .busy(busy2), .weights_ready(weights_ready2), .bus(bus2));

   always #5 clk = ~clk;

   // Synchronous ROMs: latency 1 and latency 2.
   always @(posedge clk) rom1 <= rom_mem[bus1.rom_addr];
   always @(posedge clk) begin
      rom2_a <= rom_mem[bus2.rom_addr];
      rom2_b <= rom2_a;
   end
   assign bus1.rom_dout = rom1;
   assign bus2.rom_dout = rom2_b;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [VEC_W-1:0] obs,
                        input logic [VEC_W-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Expected tap vector straight from the buffer layout rule.
   function automatic logic [VEC_W-1:0] model_vec(input logic [7:0] b, input int tp);
      logic [VEC_W-1:0] v;
      v = '0;
      for (int oc = 0; oc < OUT_CH; oc++) begin
         for (int ic = 0; ic < IN_CH; ic++) begin
            int k;
            k = oc*IN_CH*KERNEL + ic*KERNEL + tp;
            v[(oc*IN_CH+ic)*WEIGHT_W +: WEIGHT_W] = rom_mem[8'((int'(b) + k) % 256)];
         end
      end
      return v;
   endfunction

   function automatic logic [7:0] elem(input logic [VEC_W-1:0] v, input int e);
      return v[e*WEIGHT_W +: WEIGHT_W];
   endfunction

   task automatic drive_go(input int sel, input logic val);
      if (sel == 0) layer_go = val; else layer_go2 = val;
   endtask

   task automatic drive_rdy(input int sel, input logic val);
      if (sel == 0) bus1.w_ready = val; else bus2.w_ready = val;
   endtask

   // Pulses start at cycle 0 and follows the load to the first READY cycle.
   // go_at >= 0 additionally pulses layer_go at that cycle (0 = with start).
   task automatic load(input int sel, input logic [7:0] b, input int go_at, input string tag);
      int lat, bad, last;
      logic en, bz, wr, vl;
      logic [7:0] ad;
      lat  = (sel == 0) ? 1 : 2;
      last = N + lat + 1;
      bad  = 0;
      if (sel == 0) begin rom_base = b; start = 1'b1; end
      else          begin rom_base2 = b; start2 = 1'b1; end
      drive_go(sel, go_at == 0);
      tick();
      start = 1'b0; start2 = 1'b0;
      for (int i = 1; i <= last; i++) begin
         drive_go(sel, i == go_at);
         en = (sel == 0) ? bus1.rom_en   : bus2.rom_en;
         ad = (sel == 0) ? bus1.rom_addr : bus2.rom_addr;
         bz = (sel == 0) ? busy          : busy2;
         wr = (sel == 0) ? weights_ready : weights_ready2;
         vl = (sel == 0) ? bus1.w_valid  : bus2.w_valid;
         if (en !== (i <= N)) bad++;
         if ((i <= N) && (ad !== 8'((int'(b) + i - 1) % 256))) bad++;
         if (bz !== (i <= N + lat)) bad++;
         if (wr !== (i == last)) bad++;
         if (vl !== ((go_at >= 0) && (i == last))) bad++;
         if (i == 1) check({tag, "_busy_rise"}, VEC_W'(bz), VEC_W'(1));
         if (i == last) begin
            check({tag, "_ready_at_end"}, VEC_W'({wr, bz}), VEC_W'(2'b10));
            if (go_at >= 0) check({tag, "_pend_valid"}, VEC_W'(vl), VEC_W'(1));
         end
         if (i < last) tick();
      end
      drive_go(sel, 1'b0);
      check({tag, "_seq_errors"}, VEC_W'(bad), VEC_W'(0));
   endtask

   // Runs one tap sequence (optionally pulsing layer_go first) and checks
   // taps, vectors, stall stability and the emit_done pulse.
   task automatic emit(input int sel, input logic [7:0] b, input bit pulse,
                       input bit rnd, input string tag);
      int exp_tap, bad, cyc;
      bit stalled, rdy;
      logic v, dn;
      logic [TAP_W-1:0] t, pt;
      logic [VEC_W-1:0] vec, pv;
      exp_tap = 0; bad = 0; cyc = 0; stalled = 0; pt = '0; pv = '0;
      if (pulse) begin
         drive_go(sel, 1'b1);
         tick();
         drive_go(sel, 1'b0);
      end
      while ((exp_tap < KERNEL) && (cyc < 200)) begin
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         drive_rdy(sel, rdy);
         v   = (sel == 0) ? bus1.w_valid   : bus2.w_valid;
         t   = (sel == 0) ? bus1.w_tap     : bus2.w_tap;
         vec = (sel == 0) ? bus1.w_vec     : bus2.w_vec;
         dn  = (sel == 0) ? bus1.emit_done : bus2.emit_done;
         if (stalled && ((vec !== pv) || (t !== pt))) bad++;
         if (v !== 1'b1) bad++;
         if (t !== TAP_W'(exp_tap)) bad++;
         if (vec !== model_vec(b, exp_tap)) bad++;
         if (dn !== 1'b0) bad++;
         if (rdy) begin
            cap_vec[exp_tap] = vec;
            exp_tap++;
            stalled = 0;
         end else begin
            stalled = 1;
            pv = vec;
            pt = t;
         end
         tick();
         cyc++;
      end
      drive_rdy(sel, 1'b1);
      check({tag, "_taps_accepted"}, VEC_W'(exp_tap), VEC_W'(KERNEL));
      check({tag, "_tap_errors"}, VEC_W'(bad), VEC_W'(0));
      v  = (sel == 0) ? bus1.w_valid   : bus2.w_valid;
      dn = (sel == 0) ? bus1.emit_done : bus2.emit_done;
      check({tag, "_done_pulse"}, VEC_W'({dn, v}), VEC_W'(2'b10));
      tick();
      dn = (sel == 0) ? bus1.emit_done : bus2.emit_done;
      check({tag, "_done_once"}, VEC_W'(dn), VEC_W'(0));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctrl"}, VEC_W'({bus1.rom_en, bus1.rom_addr, busy, weights_ready,
            bus1.w_valid, bus1.w_tap, bus1.emit_done}), VEC_W'(0));
      check({tag, "_vec"}, bus1.w_vec, VEC_W'(0));
   endtask

   initial begin
      int bad;
      logic [7:0] rb;
      bus1.w_ready = 1'b1;
      bus2.w_ready = 1'b1;
      for (int a = 0; a < 256; a++) rom_mem[a] = 8'(a);

      // Reset state
      tick(); tick();
      check_zero("reset");
      rst = 1'b0;
      tick();

      // Identity ROM, base 0, full-rate emission
      load(0, 8'd0, -1, "load0");
      emit(0, 8'd0, 1'b1, 1'b0, "emit0");
      check("tap0_e6",  VEC_W'(elem(cap_vec[0], 6)),  VEC_W'(18));
      check("tap0_e63", VEC_W'(elem(cap_vec[0], 63)), VEC_W'(189));

      // Backpressure, repeat emission from the retained buffer
      emit(0, 8'd0, 1'b1, 1'b1, "emit_bp");
      check("tap1_e0", VEC_W'(elem(cap_vec[1], 0)), VEC_W'(1));

      // Random ROM contents from here on
      for (int a = 0; a < 256; a++) rom_mem[a] = 8'($urandom);

      // Reload from READY with layer_go mid-load, then start during EMIT
      rb = 8'($urandom);
      load(0, rb, 50, "pend");
      bus1.w_ready = 1'b0;
      start = 1'b1;
      rom_base = ~rb;
      tick();
      start = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if ((bus1.rom_en !== 1'b0) || (busy !== 1'b0) || (bus1.w_valid !== 1'b1) ||
             (bus1.w_tap !== '0) || (weights_ready !== 1'b1)) bad++;
         tick();
      end
      check("start_in_emit_ignored", VEC_W'(bad), VEC_W'(0));
      emit(0, rb, 1'b0, 1'b1, "pend_emit");

      // start and layer_go in the same READY cycle: reload, then emit
      rb = 8'($urandom);
      load(0, rb, 0, "both");
      emit(0, rb, 1'b0, 1'b0, "both_emit");

      // Latency-2 build with wrapping base
      load(1, 8'd250, -1, "lat2");
      emit(1, 8'd250, 1'b1, 1'b0, "lat2_emit");
      check("lat2_word6", VEC_W'(elem(cap_vec[0], 2)), VEC_W'(rom_mem[0]));

      // Asynchronous reset mid-load
      rom_base = 8'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < 100; i++) tick();
      rst = 1'b1;
      #1;
      check_zero("rst_load");
      tick();
      rst = 1'b0;
      tick();
      rb = 8'($urandom);
      load(0, rb, -1, "reload1");
      emit(0, rb, 1'b1, 1'b1, "reload1_emit");

      // Asynchronous reset mid-emit
      bus1.w_ready = 1'b0;
      layer_go = 1'b1;
      tick();
      layer_go = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check_zero("rst_emit");
      tick();
      rst = 1'b0;
      bus1.w_ready = 1'b1;
      tick();
      rb = 8'($urandom);
      load(0, rb, -1, "reload2");
      emit(0, rb, 1'b1, 1'b0, "reload2_emit");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end
endmodule
